evolve_timer: RTL
=================

Name: evolve_timer

Overview:
Parametrised successor of the fixed 16-cycle evolve tick. Produces a one-cycle done pulse every (period+1) enabled clock cycles, with a runtime-programmable period and a pause/enable input. Supports periodic and one-shot modes, and keeps a saturating count of completed evolutions. Sits between the game control FSM and the world-evolution logic (snowball/fireball growth steps).

Parameters:
WIDTH, 8, bit width of period input and internal cycle counter
GEN_WIDTH, 8, bit width of the evolution (generation) counter
DEFAULT_PERIOD, 15, period value loaded by clr (15 reproduces the legacy 16-cycle tick)

Ports:
clk  input  1  system clock, all logic on rising edge
clr  input  1  synchronous active-high reset; highest priority
start  input  1  begin/restart timing run; samples period and oneshot
stop  input  1  abort run, return to IDLE
oneshot  input  1  mode sampled at start: 1 = single done then IDLE, 0 = periodic
en  input  1  count enable in RUN; 0 = pause (state held)
period  input  WIDTH  terminal count; done every period+1 enabled cycles
done  output  1  registered one-cycle evolution pulse
busy  output  1  high while in RUN
count  output  WIDTH  current cycle count within period
gen  output  GEN_WIDTH  completed evolutions since last start/clr
gen_sat  output  1  high when gen is all ones

Behaviour:
- Reset (clr=1 at edge): state IDLE, done=0, busy=0, count=0, gen=0, gen_sat=0, period_q=DEFAULT_PERIOD, oneshot_q=0. Overrides all other inputs in that cycle.
- States: IDLE, RUN. busy = (state==RUN), registered with state.
- Priority at each edge: clr > stop > start > counting.
- IDLE: count held at 0, done=0. start=1 -> RUN, count=0, period_q<=period, oneshot_q<=oneshot, gen=0, gen_sat=0.
- RUN, start=1 (no stop): restart exactly as from IDLE; no done in that cycle.
- RUN, stop=1: -> IDLE, count=0, done=0, even if count==period_q; gen/gen_sat retained.
- RUN, en=0: count, gen, state held; done=0.
- RUN, en=1, count!=period_q: count<=count+1, done<=0.
- RUN, en=1, count==period_q (terminal): count<=0, done<=1, gen<=gen+1 unless saturated; if oneshot_q -> IDLE (busy falls with done rising).
- Latency: with en held 1, first done is visible period+1 cycles after the start edge; subsequent pulses every period+1 cycles.
- period_q=0: done high on every enabled cycle (continuous in periodic mode); legal, no forced gap.
- period input changes mid-run are ignored until next start.
- gen saturates at 2^GEN_WIDTH-1, no wrap; gen_sat=1 from the same edge gen reaches all ones.
- count never exceeds period_q; wrap is to 0 only at terminal.
- clr mid-run: immediate return to reset values at that edge; a terminal-count coincidence produces no done.
- All outputs registered; no combinational input-to-output path.

Test Plan:
- clr, then start with period=15, oneshot=0, en=1 -> done pulses at cycles 16, 32, 48 after start edge, each one cycle wide; gen=1,2,3.
- start with period=3, oneshot=1 -> single done at cycle 4, busy falls same edge, count=0, gen=1; no further done over 20 cycles.
- period=4 periodic, drop en for 3 cycles at count=2 -> count holds 2, done delayed exactly 3 cycles (cycle 8 instead of 5).
- period=0 periodic, en=1 -> done high every cycle; gen climbs to 255 with GEN_WIDTH=8, then holds, gen_sat=1.
- period=5, assert stop at count==5 together with start -> stop wins: IDLE, no done, busy=0; restart at count=3 -> count=0, gen=0, next done 6 cycles later.
- clr asserted during RUN at terminal count -> no done, all outputs at reset values next cycle; change period mid-run -> pulse spacing unchanged until next start.

Source files
------------

// File: rtl/evolve_timer_if.sv
// Control/status bundle between the game control FSM (master) and the
// evolve timer (slave).
interface evolve_timer_if #(
   parameter int WIDTH     = 8,
   parameter int GEN_WIDTH = 8
);
   logic                 start;
   logic                 stop;
   logic                 oneshot;
   logic                 en;
   logic [WIDTH-1:0]     period;
   logic                 done;
   logic                 busy;
   logic [WIDTH-1:0]     count;
   logic [GEN_WIDTH-1:0] gen;
   logic                 gen_sat;

   modport master (
      output start, stop, oneshot, en, period,
      input  done, busy, count, gen, gen_sat
   );

   modport slave (
      input  start, stop, oneshot, en, period,
      output done, busy, count, gen, gen_sat
   );
endinterface

// File: rtl/evolve_timer.sv
// Programmable-period evolution tick: one-cycle done every period+1 enabled
// cycles, with pause, one-shot mode and a saturating generation counter.
module evolve_timer #(
   parameter int WIDTH          = 8,
   parameter int GEN_WIDTH      = 8,
   parameter int DEFAULT_PERIOD = 15
) (
   input  logic          clk,
   input  logic          clr,
   evolve_timer_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   state_t               state;
   logic [WIDTH-1:0]     count_q;
   logic [WIDTH-1:0]     period_q;
   logic                 oneshot_q;
   logic                 done_q;
   logic                 busy_q;
   logic [GEN_WIDTH-1:0] gen_q;
   logic                 gen_sat_q;
   logic                 restart;
   logic                 terminal;
   logic [GEN_WIDTH-1:0] gen_next;

   function automatic logic [GEN_WIDTH-1:0] gen_sat_inc(input logic [GEN_WIDTH-1:0] v);
      return (&v) ? v : v + GEN_WIDTH'(1);
   endfunction

   // stop outranks start, so a simultaneous stop+start only aborts.
   assign restart  = bus.start && !bus.stop;
   assign terminal = (count_q == period_q);
   assign gen_next = gen_sat_inc(gen_q);

   always_ff @(posedge clk) begin
      if (clr) begin
         state     <= IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         count_q   <= '0;
         period_q  <= WIDTH'(DEFAULT_PERIOD);
         oneshot_q <= 1'b0;
         gen_q     <= '0;
         gen_sat_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (restart) begin
            state     <= RUN;
            busy_q    <= 1'b1;
            count_q   <= '0;
            period_q  <= bus.period;
            oneshot_q <= bus.oneshot;
            gen_q     <= '0;
            gen_sat_q <= 1'b0;
         end else begin
            unique case (state)
               IDLE: begin
                  count_q <= '0;
               end
               RUN: begin
                  if (bus.stop) begin
                     state   <= IDLE;
                     busy_q  <= 1'b0;
                     count_q <= '0;
                  end else if (bus.en) begin
                     if (terminal) begin
                        count_q   <= '0;
                        done_q    <= 1'b1;
                        gen_q     <= gen_next;
                        gen_sat_q <= &gen_next;
                        // One-shot: busy falls on the same edge done rises.
                        if (oneshot_q) begin
                           state  <= IDLE;
                           busy_q <= 1'b0;
                        end
                     end else begin
                        count_q <= count_q + WIDTH'(1);
                     end
                  end
               end
               default: begin
                  state  <= IDLE;
                  busy_q <= 1'b0;
               end
            endcase
         end
      end
   end

   assign bus.done    = done_q;
   assign bus.busy    = busy_q;
   assign bus.count   = count_q;
   assign bus.gen     = gen_q;
   assign bus.gen_sat = gen_sat_q;

   // Run invariants: count never passes the latched period; busy mirrors state.
   a_count_in_range : assert property (@(posedge clk) disable iff (clr) count_q <= period_q);
   a_busy_state     : assert property (@(posedge clk) disable iff (clr) busy_q == (state == RUN));
endmodule
